// File: rtl/dram_model_pkg.sv
// Shared types and helpers for the burst DRAM model.
// Latency: n/a (types, constants and an elaboration-time function only).
// Backpressure: n/a.
package dram_model_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST_WAIT,
        ST_XFER,
        ST_GAP_WAIT,
        ST_TAIL
    } state_t;

    localparam int ARB_WRITE_PRIO  = 0;
    localparam int ARB_ROUND_ROBIN = 1;

    // One counter serves all three wait phases; it counts 0..lat-1, so it
    // must hold the largest latency minus one (at least one bit wide).
    function automatic int lat_cnt_w(input int first_lat, input int gap_lat, input int tail_lat);
        int m;
        m = first_lat;
        if (gap_lat > m) m = gap_lat;
        if (tail_lat > m) m = tail_lat;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/dram_model_mem.sv
// Storage for the burst DRAM model: one write port, one registered read port.
// Latency: write lands at the clock edge; read word appears one cycle after rd_en.
// Backpressure: none; the read word holds until the next rd_en.
// Ports: clock/rst; wr_en/wr_idx/wr_word write port; rd_en/rd_idx read request,
//        rd_word registered read data (cleared by rst, contents are not).
module dram_model_mem #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 10
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [MEM_AW-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_word,
    input  logic              rd_en,
    input  logic [MEM_AW-1:0] rd_idx,
    output logic [DATA_W-1:0] rd_word
);

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_idx] <= wr_word;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst)        rd_word <= '0;
        else if (rd_en) rd_word <= mem[rd_idx];
    end

endmodule

// File: rtl/dram_burst_model.sv
// Behavioural burst DRAM: write and read request channels share one array.
// Latency: first word FIRST_LAT+1 cycles after grant, then one word per GAP_LAT+1.
// Backpressure: requests are ignored while busy; dropping the granted request aborts.
// Ports: clock/rst; dram_wr_req/addr/data in, dram_wr_val/done out;
//        dram_rd_req/addr in, dram_rd_data/val/done out; dram_busy out.
module dram_burst_model
    import dram_model_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_AW    = 10,
    parameter int BURST_LEN = 8,
    parameter int FIRST_LAT = 15,
    parameter int GAP_LAT   = 6,
    parameter int TAIL_LAT  = 3,
    parameter int ARB_MODE  = ARB_WRITE_PRIO
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              dram_wr_req,
    input  logic [ADDR_W-1:0] dram_wr_addr,
    input  logic [DATA_W-1:0] dram_wr_data,
    output logic              dram_wr_val,
    output logic              dram_wr_done,
    input  logic              dram_rd_req,
    input  logic [ADDR_W-1:0] dram_rd_addr,
    output logic [DATA_W-1:0] dram_rd_data,
    output logic              dram_rd_val,
    output logic              dram_rd_done,
    output logic              dram_busy
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int LAT_W = lat_cnt_w(FIRST_LAT, GAP_LAT, TAIL_LAT);

    localparam logic [LAT_W-1:0] FIRST_END = LAT_W'(FIRST_LAT - 1);
    localparam logic [LAT_W-1:0] GAP_END   = LAT_W'(GAP_LAT - 1);
    localparam logic [LAT_W-1:0] TAIL_END  = LAT_W'((TAIL_LAT > 0) ? TAIL_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_LEN - 1);

    state_t            state;
    logic              op_wr;      // current burst is a write
    logic              last_wr;    // last grant went to write (resets to read)
    logic [MEM_AW-1:0] base;
    logic [CNT_W-1:0]  cnt;
    logic [LAT_W-1:0]  lat;

    logic              grant_wr;
    logic              req_held;
    logic              xfer;
    logic [MEM_AW-1:0] idx;

    // Only the low MEM_AW address bits select storage; the rest are ignored.
    logic              addr_unused;
    assign addr_unused = ^{dram_wr_addr, dram_rd_addr};

    // Round-robin ties go to the channel not granted last; otherwise write wins.
    assign grant_wr = dram_wr_req &&
                      (!dram_rd_req || (ARB_MODE == ARB_WRITE_PRIO) || !last_wr);
    assign req_held = op_wr ? dram_wr_req : dram_rd_req;
    assign xfer     = (state == ST_XFER);
    // Index wraps modulo the storage depth.
    assign idx      = base + MEM_AW'(cnt);

    dram_model_mem #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clock   (clock),
        .rst     (rst),
        .wr_en   (xfer && op_wr),
        .wr_idx  (idx),
        .wr_word (dram_wr_data),
        .rd_en   (xfer && !op_wr),
        .rd_idx  (idx),
        .rd_word (dram_rd_data)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_wr        <= 1'b0;
            last_wr      <= 1'b0;
            base         <= '0;
            cnt          <= '0;
            lat          <= '0;
            dram_wr_val  <= 1'b0;
            dram_wr_done <= 1'b0;
            dram_rd_val  <= 1'b0;
            dram_rd_done <= 1'b0;
            dram_busy    <= 1'b0;
        end else begin
            dram_wr_val  <= 1'b0;
            dram_wr_done <= 1'b0;
            dram_rd_val  <= 1'b0;
            dram_rd_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dram_wr_req || dram_rd_req) begin
                        op_wr     <= grant_wr;
                        last_wr   <= grant_wr;
                        base      <= grant_wr ? dram_wr_addr[MEM_AW-1:0]
                                              : dram_rd_addr[MEM_AW-1:0];
                        cnt       <= '0;
                        lat       <= '0;
                        state     <= ST_FIRST_WAIT;
                        dram_busy <= 1'b1;
                    end
                end
                ST_FIRST_WAIT, ST_GAP_WAIT: begin
                    if (lat == ((state == ST_FIRST_WAIT) ? FIRST_END : GAP_END)) begin
                        lat <= '0;
                        // Requester gave up: abandon the burst without a done pulse.
                        if (req_held) begin
                            state <= ST_XFER;
                        end else begin
                            state     <= ST_IDLE;
                            dram_busy <= 1'b0;
                        end
                    end else begin
                        lat <= lat + 1'b1;
                    end
                end
                ST_XFER: begin
                    cnt <= cnt + 1'b1;
                    if (op_wr) dram_wr_val <= 1'b1;
                    else       dram_rd_val <= 1'b1;
                    if (cnt == CNT_LAST) begin
                        if (op_wr) begin
                            dram_wr_done <= 1'b1;
                            state        <= ST_IDLE;
                            dram_busy    <= 1'b0;
                        end else if (TAIL_LAT == 0) begin
                            dram_rd_done <= 1'b1;
                            state        <= ST_IDLE;
                            dram_busy    <= 1'b0;
                        end else begin
                            state <= ST_TAIL;
                        end
                    end else begin
                        state <= ST_GAP_WAIT;
                    end
                end
                ST_TAIL: begin
                    // Done is registered, so it shows as the tail closes and busy drops.
                    if (lat == TAIL_END) begin
                        lat          <= '0;
                        dram_rd_done <= 1'b1;
                        state        <= ST_IDLE;
                        dram_busy    <= 1'b0;
                    end else begin
                        lat <= lat + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    dram_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_burst_model.sv
// Bench for dram_burst_model: three configurations checked cycle by cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_dram_burst_model;

    // 0: default config, 1: small wrapping round-robin, 2: single-word corner.
    localparam int CFG_AW  [3] = '{10, 4, 4};
    localparam int CFG_BL  [3] = '{8, 8, 1};
    localparam int CFG_FL  [3] = '{15, 3, 1};
    localparam int CFG_GL  [3] = '{6, 2, 1};
    localparam int CFG_TL  [3] = '{3, 2, 0};
    localparam int CFG_ARB [3] = '{0, 1, 1};

    logic        clock;
    logic        rst;
    logic        wr_req  [3];
    logic [31:0] wr_addr [3];
    logic [31:0] wr_data [3];
    logic        wr_val  [3];
    logic        wr_done [3];
    logic        rd_req  [3];
    logic [31:0] rd_addr [3];
    logic [31:0] rd_data [3];
    logic        rd_val  [3];
    logic        rd_done [3];
    logic        busy    [3];

    // Reference state
    logic [31:0] ref_mem   [3][1024];
    bit          ref_known [3][1024];
    bit          wr_pend [3];
    bit          rd_pend [3];
    bit          last_rd [3];
    logic [31:0] last_waddr [3];
    logic [31:0] wwords [8];

    int n_checks;
    int n_pass;
    int n_fail;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dram_burst_model #(
            .DATA_W    (32),
            .ADDR_W    (32),
            .MEM_AW    (CFG_AW[g]),
            .BURST_LEN (CFG_BL[g]),
            .FIRST_LAT (CFG_FL[g]),
            .GAP_LAT   (CFG_GL[g]),
            .TAIL_LAT  (CFG_TL[g]),
            .ARB_MODE  (CFG_ARB[g])
        ) dut (
            .clock        (clock),
            .rst          (rst),
            .dram_wr_req  (wr_req[g]),
            .dram_wr_addr (wr_addr[g]),
            .dram_wr_data (wr_data[g]),
            .dram_wr_val  (wr_val[g]),
            .dram_wr_done (wr_done[g]),
            .dram_rd_req  (rd_req[g]),
            .dram_rd_addr (rd_addr[g]),
            .dram_rd_data (rd_data[g]),
            .dram_rd_val  (rd_val[g]),
            .dram_rd_done (rd_done[g]),
            .dram_busy    (busy[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drop(input int k, input bit gw);
        if (gw) begin
            wr_req[k]  = 1'b0;
            wr_pend[k] = 1'b0;
        end else begin
            rd_req[k]  = 1'b0;
            rd_pend[k] = 1'b0;
        end
    endtask

    task automatic check_quiet(input int k, input string what, input bit with_data);
        check_eq($sformatf("d%0d %s wr_val", k, what), 32'(wr_val[k]), 32'd0);
        check_eq($sformatf("d%0d %s wr_done", k, what), 32'(wr_done[k]), 32'd0);
        check_eq($sformatf("d%0d %s rd_val", k, what), 32'(rd_val[k]), 32'd0);
        check_eq($sformatf("d%0d %s rd_done", k, what), 32'(rd_done[k]), 32'd0);
        check_eq($sformatf("d%0d %s busy", k, what), 32'(busy[k]), 32'd0);
        if (with_data) check_eq($sformatf("d%0d %s rd_data", k, what), rd_data[k], 32'd0);
    endtask

    task automatic idle_check(input int k, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clock); #1;
            check_quiet(k, "idle", 1'b0);
        end
    endtask

    // Serve one grant. Called in the cycle the model sees the DUT idle with
    // requests already driven; returns in the cycle the burst is over.
    // stop_kind: 0 full burst, 1 drop request after stop_n words, 2 reset after stop_n words.
    task automatic serve(input int k, input int stop_n, input int stop_kind);
        int fl, gl, tl, bl, depth, base, nw, r_first, step, r_end, i, idx;
        bit gw, ev, ed, eb;
        fl = CFG_FL[k]; gl = CFG_GL[k]; tl = CFG_TL[k]; bl = CFG_BL[k];
        depth = 1 << CFG_AW[k];
        gw = wr_pend[k] && (!rd_pend[k] || CFG_ARB[k] == 0 || last_rd[k]);
        last_rd[k] = !gw;
        base = int'((gw ? wr_addr[k] : rd_addr[k]) % 32'(depth));
        nw = (stop_kind != 0) ? stop_n : bl;
        r_first = fl + 2;
        step = gl + 1;
        if (stop_kind == 1)      r_end = fl + 1 + stop_n * step;
        else if (stop_kind == 2) r_end = r_first + (stop_n - 1) * step;
        else                     r_end = r_first + (bl - 1) * step + (gw ? 0 : tl);

        for (int r = 1; r <= r_end; r++) begin
            @(posedge clock); #1;
            ev = (r >= r_first) && ((r - r_first) % step == 0) && ((r - r_first) / step < nw);
            ed = (stop_kind == 0) && (r == r_end);
            eb = (stop_kind == 2) ? 1'b1 : (r < r_end);
            check_eq($sformatf("d%0d r%0d wr_val", k, r), 32'(wr_val[k]), 32'(gw && ev));
            check_eq($sformatf("d%0d r%0d rd_val", k, r), 32'(rd_val[k]), 32'(!gw && ev));
            check_eq($sformatf("d%0d r%0d wr_done", k, r), 32'(wr_done[k]), 32'(gw && ed));
            check_eq($sformatf("d%0d r%0d rd_done", k, r), 32'(rd_done[k]), 32'(!gw && ed));
            check_eq($sformatf("d%0d r%0d busy", k, r), 32'(busy[k]), 32'(eb));
            if (ev) begin
                i = (r - r_first) / step;
                idx = (base + i) % depth;
                if (gw) begin
                    ref_mem[k][idx] = wr_data[k];
                    ref_known[k][idx] = 1'b1;
                    if (i + 1 < 8) wr_data[k] = wwords[i + 1];
                end else if (ref_known[k][idx]) begin
                    check_eq($sformatf("d%0d rd_data idx 0x%0h", k, idx), rd_data[k], ref_mem[k][idx]);
                end
                if (stop_kind == 1 && i == nw - 1) drop(k, gw);
            end
            if (ed) drop(k, gw);
        end

        if (stop_kind == 2) begin
            #2 rst = 1'b1;
            #1 check_quiet(k, "async rst", 1'b1);
            #1 rst = 1'b0;
            wr_req[k] = 1'b0; rd_req[k] = 1'b0;
            wr_pend[k] = 1'b0; rd_pend[k] = 1'b0;
            for (int j = 0; j < 3; j++) last_rd[j] = 1'b1;
        end
    endtask

    task automatic episode(input int k, input bit ww, input bit wrd, input logic [31:0] waddr,
                           input logic [31:0] raddr, input int stop_n, input int stop_kind);
        wr_addr[k] = waddr;
        rd_addr[k] = raddr;
        wr_data[k] = wwords[0];
        wr_req[k]  = ww;  wr_pend[k] = ww;
        rd_req[k]  = wrd; rd_pend[k] = wrd;
        if (ww) last_waddr[k] = waddr;
        serve(k, stop_n, stop_kind);
        while (wr_pend[k] || rd_pend[k]) serve(k, 0, 0);
        idle_check(k, CFG_GL[k] + 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int depth, sn, kind;
        bit ww, wrd;
        logic [31:0] waddr, raddr;
        n_checks = 0; n_pass = 0; n_fail = 0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_req[k] = 1'b0; rd_req[k] = 1'b0;
            wr_addr[k] = '0; rd_addr[k] = '0; wr_data[k] = '0;
            wr_pend[k] = 1'b0; rd_pend[k] = 1'b0; last_rd[k] = 1'b1;
            last_waddr[k] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) check_quiet(k, "reset", 1'b1);
        rst = 1'b0;
        @(posedge clock); #1;

        // Default config: write 0x10 with A0..A7, read back, tie, abort, reset mid-write.
        for (int j = 0; j < 8; j++) wwords[j] = 32'hA0 + 32'(j);
        episode(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, 0);
        episode(0, 1'b0, 1'b1, 32'h0, 32'h10, 0, 0);
        for (int j = 0; j < 8; j++) wwords[j] = $urandom;
        episode(0, 1'b1, 1'b1, 32'h200, 32'h10, 0, 0);
        episode(0, 1'b0, 1'b1, 32'h0, 32'h10, 3, 1);
        for (int j = 0; j < 8; j++) wwords[j] = 32'hB0 + 32'(j);
        episode(0, 1'b1, 1'b0, 32'h10, 32'h0, 3, 2);
        episode(0, 1'b0, 1'b1, 32'h0, 32'hFFFF_0010, 0, 0);

        // Small memory: wrap from 0xE, then two back-to-back round-robin ties.
        for (int j = 0; j < 8; j++) wwords[j] = $urandom;
        episode(1, 1'b1, 1'b0, 32'hE, 32'h0, 0, 0);
        episode(1, 1'b0, 1'b1, 32'h0, 32'hE, 0, 0);
        episode(1, 1'b1, 1'b1, 32'h3, 32'hE, 0, 0);
        episode(1, 1'b1, 1'b1, 32'h9, 32'h3, 0, 0);

        // Single-word corner.
        wwords[0] = 32'h5A5A_1234;
        episode(2, 1'b1, 1'b0, 32'h5, 32'h0, 0, 0);
        episode(2, 1'b0, 1'b1, 32'h0, 32'h5, 0, 0);

        // Randomized traffic on each configuration.
        for (int k = 0; k < 3; k++) begin
            depth = 1 << CFG_AW[k];
            for (int e = 0; e < 10; e++) begin
                ww  = 1'($urandom_range(0, 1));
                wrd = ww ? 1'($urandom_range(0, 1)) : 1'b1;
                for (int j = 0; j < 8; j++) wwords[j] = $urandom;
                waddr = $urandom;
                raddr = ($urandom & ~32'(depth - 1)) | (last_waddr[k] & 32'(depth - 1));
                kind = (CFG_BL[k] > 1 && $urandom_range(0, 3) == 0) ? 1 : 0;
                sn = (kind == 1) ? int'($urandom_range(1, CFG_BL[k] - 1)) : 0;
                episode(k, ww, wrd, waddr, raddr, sn, kind);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
